// File: rtl/tpc_pkg.sv
// Shared types, default timing and sensor helpers for the traffic phase controller.
package tpc_pkg;

  typedef enum logic [1:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALL_RED
  } tpc_state_e;

  localparam int DEF_NUM_PHASES   = 4;
  localparam int DEF_LANES        = 4;
  localparam int DEF_CNT_W        = 5;
  localparam int DEF_GREEN_TIME   = 20;
  localparam int DEF_YELLOW_TIME  = 3;
  localparam int DEF_ALL_RED_TIME = 1;
  localparam int DEF_IDLE_DIV     = 2;

  // Upper bound on NUM_PHASES*LANES; the sensor bus is zero-padded to this width.
  localparam int unsigned LANE_BUS_W = 256;

  function automatic logic phase_has_car(input logic [LANE_BUS_W-1:0] bus,
                                         input int unsigned p,
                                         input int unsigned lanes);
    logic any;
    any = 1'b0;
    for (int unsigned l = 0; l < LANE_BUS_W; l++) begin
      if (l < lanes && (p * lanes + l) < LANE_BUS_W) begin
        any = any | bus[p * lanes + l];
      end
    end
    return any;
  endfunction

endpackage

// File: rtl/tpc_rr_pick.sv
// Round-robin picker: first set request at or after start, wrapping at N-1.
module tpc_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int unsigned c;

  always_comb begin
    found = 1'b0;
    idx   = start;
    c     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      c = int'(start) + i;
      if (c >= N) begin
        c = c - N;
      end
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = W'(c);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-phase intersection controller: round-robin GREEN/YELLOW/ALL_RED service
// of demanded phases, idle-rate green timing and emergency preemption.
module traffic_phase_ctrl
  import tpc_pkg::*;
#(
  parameter int NUM_PHASES   = DEF_NUM_PHASES,
  parameter int LANES        = DEF_LANES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int GREEN_TIME   = DEF_GREEN_TIME,
  parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
  parameter int ALL_RED_TIME = DEF_ALL_RED_TIME,
  parameter int IDLE_DIV     = DEF_IDLE_DIV,
  parameter int PH_W         = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PHASES*LANES-1:0] cars,
  input  logic                        preempt,
  input  logic [PH_W-1:0]             preempt_phase,
  output logic [NUM_PHASES-1:0]       green,
  output logic [NUM_PHASES-1:0]       yellow,
  output logic [NUM_PHASES-1:0]       red,
  output logic [CNT_W-1:0]            count_down,
  output logic [PH_W-1:0]             active_phase,
  output logic [NUM_PHASES-1:0]       demand
);

  localparam int PS_W = (IDLE_DIV > 1) ? $clog2(IDLE_DIV) : 1;

  localparam logic [CNT_W-1:0]      GREEN_LD  = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0]      YELLOW_LD = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0]      ALLRED_LD = CNT_W'(ALL_RED_TIME);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [PS_W-1:0]       PS_LAST   = PS_W'(IDLE_DIV - 1);
  localparam logic [NUM_PHASES-1:0] PH0_OH    = NUM_PHASES'(1);

  tpc_state_e state, state_n;

  logic [PH_W-1:0]       phase_n;
  logic [PH_W-1:0]       start_idx;
  logic [PH_W-1:0]       pick_idx;
  logic [PH_W-1:0]       next_phase;
  logic                  pick_found;
  logic [CNT_W-1:0]      count_n;
  logic [PS_W-1:0]       prescaler, presc_n;
  logic [NUM_PHASES-1:0] demand_n;
  logic [NUM_PHASES-1:0] car_any;
  logic [NUM_PHASES-1:0] act_oh;
  logic [NUM_PHASES-1:0] next_oh;
  logic [NUM_PHASES-1:0] clr_oh;
  logic [NUM_PHASES-1:0] own_mask;
  logic                  pre_valid, pre_other, pre_self;
  logic                  competing, tick;
  logic [LANE_BUS_W-1:0] lane_bus;

  always_comb begin
    lane_bus                       = '0;
    lane_bus[NUM_PHASES*LANES-1:0] = cars;
    car_any                        = '0;
    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      car_any[p] = phase_has_car(lane_bus, p, LANES);
    end
  end

  always_comb begin
    act_oh    = PH0_OH << active_phase;
    pre_valid = preempt && (int'(preempt_phase) < NUM_PHASES);
    pre_other = pre_valid && (preempt_phase != active_phase);
    pre_self  = pre_valid && (preempt_phase == active_phase);
    competing = (|(demand & ~act_oh)) || pre_other;
    start_idx = (int'(active_phase) == NUM_PHASES - 1) ? '0 : active_phase + PH_W'(1);
  end

  // Searching from active+1 leaves the active phase's own demand for last.
  tpc_rr_pick #(
    .N (NUM_PHASES),
    .W (PH_W)
  ) u_pick (
    .req   (demand),
    .start (start_idx),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    if (pre_valid) begin
      next_phase = preempt_phase;
    end else if (pick_found) begin
      next_phase = pick_idx;
    end else begin
      next_phase = start_idx;
    end
    next_oh = PH0_OH << next_phase;
  end

  always_comb begin
    state_n = state;
    phase_n = active_phase;
    count_n = count_down;
    presc_n = prescaler;
    clr_oh  = '0;
    tick    = 1'b0;
    unique case (state)
      ST_GREEN: begin
        if (pre_other) begin
          state_n = ST_YELLOW;
          count_n = YELLOW_LD;
          presc_n = '0;
        end else if (!pre_self) begin
          if (competing || prescaler == PS_LAST) begin
            tick    = 1'b1;
            presc_n = '0;
          end else begin
            presc_n = prescaler + PS_W'(1);
          end
          if (tick) begin
            if (count_down > CNT_ONE) begin
              count_n = count_down - CNT_ONE;
            end else begin
              state_n = ST_YELLOW;
              count_n = YELLOW_LD;
            end
          end
        end
      end
      ST_YELLOW: begin
        presc_n = '0;
        if (count_down > CNT_ONE) begin
          count_n = count_down - CNT_ONE;
        end else begin
          state_n = ST_ALL_RED;
          count_n = ALLRED_LD;
        end
      end
      ST_ALL_RED: begin
        presc_n = '0;
        if (count_down > CNT_ONE) begin
          count_n = count_down - CNT_ONE;
        end else begin
          state_n = ST_GREEN;
          phase_n = next_phase;
          count_n = GREEN_LD;
          clr_oh  = next_oh;
        end
      end
      default: begin
        state_n = ST_GREEN;
        count_n = GREEN_LD;
        presc_n = '0;
      end
    endcase
  end

  // Clear is applied after set so a phase entering green drops its demand.
  always_comb begin
    own_mask = (state == ST_GREEN) ? act_oh : '0;
    demand_n = (demand | (car_any & ~own_mask)) & ~clr_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_GREEN;
      active_phase <= '0;
      count_down   <= GREEN_LD;
      demand       <= '0;
      prescaler    <= '0;
    end else begin
      state        <= state_n;
      active_phase <= phase_n;
      count_down   <= count_n;
      demand       <= demand_n;
      prescaler    <= presc_n;
    end
  end

  always_comb begin
    green  = (state == ST_GREEN)  ? act_oh : '0;
    yellow = (state == ST_YELLOW) ? act_oh : '0;
    red    = ~(green | yellow);
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_traffic_phase_ctrl;

  localparam int NP = 4;
  localparam int LN = 4;
  localparam int CW = 5;
  localparam int GT = 20;
  localparam int YT = 3;
  localparam int AT = 1;
  localparam int ID = 2;
  localparam int PW = 2;
  localparam int CB = NP * LN;

  logic          clk = 1'b0;
  logic          rst;
  logic [CB-1:0] cars;
  logic          preempt;
  logic [PW-1:0] preempt_phase;
  logic [NP-1:0] green, yellow, red, demand;
  logic [CW-1:0] count_down;
  logic [PW-1:0] active_phase;

  traffic_phase_ctrl #(
    .NUM_PHASES   (NP),
    .LANES        (LN),
    .CNT_W        (CW),
    .GREEN_TIME   (GT),
    .YELLOW_TIME  (YT),
    .ALL_RED_TIME (AT),
    .IDLE_DIV     (ID),
    .PH_W         (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cars          (cars),
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
    .green         (green),
    .yellow        (yellow),
    .red           (red),
    .count_down    (count_down),
    .active_phase  (active_phase),
    .demand        (demand)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: stage 0=green 1=yellow 2=all-red, ticks left, idle cycles since last tick.
  int          m_stage, m_phase, m_left, m_sub;
  bit [NP-1:0] m_dem;

  task automatic model_step();
    bit          valid, other, tick, found;
    bit [NP-1:0] nd;
    int          nxt;
    if (rst) begin
      m_stage = 0; m_phase = 0; m_left = GT; m_sub = 0; m_dem = '0;
    end else begin
      valid = preempt && (int'(preempt_phase) < NP);
      other = 1'b0;
      for (int q = 0; q < NP; q++) if (q != m_phase && m_dem[q]) other = 1'b1;
      nd = m_dem;
      for (int p = 0; p < NP; p++)
        if ((|cars[p*LN +: LN]) && !(m_stage == 0 && p == m_phase)) nd[p] = 1'b1;
      case (m_stage)
        0: begin
          if (valid && int'(preempt_phase) != m_phase) begin
            m_stage = 1; m_left = YT; m_sub = 0;
          end else if (!valid) begin
            tick = 1'b0;
            if (other) begin
              tick = 1'b1; m_sub = 0;
            end else begin
              m_sub++;
              if (m_sub == ID) begin tick = 1'b1; m_sub = 0; end
            end
            if (tick) begin
              if (m_left == 1) begin m_stage = 1; m_left = YT; end
              else m_left--;
            end
          end
        end
        1: begin
          if (m_left == 1) begin m_stage = 2; m_left = AT; end
          else m_left--;
        end
        default: begin
          if (m_left == 1) begin
            if (valid) nxt = int'(preempt_phase);
            else begin
              nxt   = (m_phase + 1) % NP;
              found = 1'b0;
              for (int k = 1; k <= NP; k++)
                if (!found && m_dem[(m_phase + k) % NP]) begin
                  found = 1'b1; nxt = (m_phase + k) % NP;
                end
            end
            m_stage = 0; m_phase = nxt; m_left = GT; m_sub = 0; nd[nxt] = 1'b0;
          end else m_left--;
        end
      endcase
      m_dem = nd;
    end
  endtask

  task automatic compare();
    logic [NP-1:0] eg, ey, er;
    eg = (m_stage == 0) ? (NP'(1) << m_phase) : '0;
    ey = (m_stage == 1) ? (NP'(1) << m_phase) : '0;
    er = ~(eg | ey);
    checks++;
    if (green !== eg || yellow !== ey || red !== er || count_down !== CW'(m_left) ||
        active_phase !== PW'(m_phase) || demand !== m_dem) begin
      failures++;
      $display("FAIL model cyc=%0d green=%b exp=%b yellow=%b exp=%b red=%b exp=%b count=%0d exp=%0d phase=%0d exp=%0d demand=%b exp=%b",
               cyc, green, eg, yellow, ey, red, er, count_down, m_left, active_phase, m_phase, demand, m_dem);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cars = '0; preempt = 1'b0; preempt_phase = '0;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 200 && cyc < target; n++) step();
  endtask

  task automatic run_until_green_not(input logic [NP-1:0] cur);
    for (int n = 0; n < 120 && (green == '0 || green == cur); n++) step();
  endtask

  initial begin
    rst = 1'b1; cars = '0; preempt = 1'b0; preempt_phase = '0;

    // Idle timing from reset and wrap to phase 1.
    do_reset();
    lit("rst_green", green, 4'b0001);
    lit("rst_yellow", yellow, 0);
    lit("rst_red", red, 4'b1110);
    lit("rst_count", count_down, 20);
    lit("rst_demand", demand, 0);
    lit("rst_phase", active_phase, 0);
    run_to(2);  lit("idle_count_c2", count_down, 19);
    run_to(40); lit("yellow_c40", yellow, 4'b0001); lit("ycount_c40", count_down, 3);
    run_to(43); lit("allred_c43", green | yellow, 0);
    run_to(44); lit("green1_c44", green, 4'b0010); lit("gcount_c44", count_down, 20);

    // Demand pulse on phase 2 speeds up green and skips phase 1.
    do_reset();
    run_to(4);
    lit("pulse_count_c4", count_down, 18);
    cars = 16'h0100;
    step();
    cars = '0;
    lit("pulse_demand", demand, 4'b0100);
    run_to(7); lit("fast_count_c7", count_down, 16);
    run_until_green_not(4'b0001);
    lit("skip_to_green2", green, 4'b0100);
    lit("green2_demand_clr", demand, 0);

    // Preempt to phase 3, freeze while held, then wrap 3 -> 0.
    do_reset();
    run_to(10); lit("pre_count_c10", count_down, 15);
    preempt = 1'b1; preempt_phase = 2'd3;
    step();
    lit("pre_yellow_c11", yellow, 4'b0001); lit("pre_ycount_c11", count_down, 3);
    run_to(14); lit("pre_allred_c14", green | yellow, 0);
    run_to(15); lit("pre_green3_c15", green, 4'b1000); lit("pre_gcount_c15", count_down, 20);
    run_to(20); lit("pre_frozen_c20", count_down, 20);
    preempt = 1'b0;
    run_to(22); lit("pre_resume_c22", count_down, 19);
    run_until_green_not(4'b1000);
    lit("wrap_to_green0", green, 4'b0001);

    // Reset dominates mid-yellow of phase 2.
    do_reset();
    preempt = 1'b1; preempt_phase = 2'd2;
    run_to(5); lit("pre2_green_c5", green, 4'b0100);
    preempt_phase = 2'd1;
    step();
    lit("y2_c6", yellow, 4'b0100);
    rst = 1'b1; cars = '1;
    step();
    rst = 1'b0; cars = '0; preempt = 1'b0;
    lit("midy_rst_green", green, 4'b0001);
    lit("midy_rst_yellow", yellow, 0);
    lit("midy_rst_count", count_down, 20);
    lit("midy_rst_demand", demand, 0);

    // Phase 2 active with demand on 1 and 3: 3 first, then 1.
    do_reset();
    preempt = 1'b1; preempt_phase = 2'd2;
    run_to(5);
    preempt = 1'b0;
    cars = 16'h1010;
    step();
    cars = '0;
    lit("dual_demand", demand, 4'b1010);
    run_until_green_not(4'b0100);
    lit("dual_first_green3", green, 4'b1000);
    lit("dual_keep_demand1", demand, 4'b0010);
    run_until_green_not(4'b1000);
    lit("dual_then_green1", green, 4'b0010);

    // Randomized traffic, preempt episodes and occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cars = '0;
      if ($urandom_range(0, 7) == 0) cars[$urandom_range(0, CB-1)] = 1'b1;
      if ($urandom_range(0, 31) == 0) cars = CB'($urandom);
      if ($urandom_range(0, 59) == 0) preempt = ~preempt;
      if ($urandom_range(0, 29) == 0) preempt_phase = PW'($urandom_range(0, NP-1));
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised multi-phase intersection controller.
- Serves NUM_PHASES signal groups round-robin through GREEN -> YELLOW -> ALL_RED, skipping phases with no latched demand.
- Green time runs at full rate while another phase has demand; otherwise it runs at 1/IDLE_DIV rate.
- Adds an emergency preempt that forces a chosen phase green and holds it there.

Parameters:
- NUM_PHASES, 4, number of signal groups (>=2).
- LANES, 4, car sensors per phase.
- CNT_W, 5, countdown width.
- GREEN_TIME, 20, green duration in ticks (1..2^CNT_W-1).
- YELLOW_TIME, 3, yellow duration in ticks (>=1).
- ALL_RED_TIME, 1, all-red clearance in ticks (>=1).
- IDLE_DIV, 2, prescale factor for green ticks when there is no competing demand (>=1).
- PH_W, max(1,$clog2(NUM_PHASES)), phase index width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cars  in  NUM_PHASES*LANES  sensor bits; phase p owns bits [p*LANES +: LANES].
- preempt  in  1  emergency request, level.
- preempt_phase  in  PH_W  requested phase; values >= NUM_PHASES are ignored.
- green  out  NUM_PHASES  one-hot, active phase in GREEN.
- yellow  out  NUM_PHASES  one-hot, active phase in YELLOW.
- red  out  NUM_PHASES  asserted for every phase that is not green or yellow.
- count_down  out  CNT_W  remaining ticks in the current state.
- active_phase  out  PH_W  phase currently or last served.
- demand  out  NUM_PHASES  latched demand register.

Behaviour:
- Reset (synchronous, on rst=1 at clk edge):
  - state=GREEN, active_phase=0, count_down=GREEN_TIME, demand=0, prescaler=0.
  - green=1 on phase 0; yellow=0; red set for all other phases.
  - rst dominates every other input in any state, including mid-yellow.
- Demand:
  - demand[p] is set on any cycle where OR(lanes of p)=1.
  - demand[p] is cleared on the cycle phase p enters GREEN.
  - In GREEN, the active phase's own sensors do not set demand.
  - Set and clear in the same cycle: clear wins.
- Tick generation:
  - YELLOW and ALL_RED tick every cycle.
  - GREEN ticks every cycle if any demand[q] with q != active_phase is set, or if preempt is valid for another phase.
  - Otherwise GREEN ticks once per IDLE_DIV cycles: prescaler counts 0..IDLE_DIV-1 and the tick fires at IDLE_DIV-1.
  - The prescaler clears on every state change and on every cycle with competing demand.
- Counter:
  - On a tick with count_down>1: decrement.
  - On a tick with count_down==1: transition and load the next duration.
  - Each state therefore lasts exactly its duration in ticks. Outputs are registered and change on the transition edge.
- FSM:
  - GREEN -> YELLOW (load YELLOW_TIME).
  - YELLOW -> ALL_RED (load ALL_RED_TIME).
  - ALL_RED -> GREEN of the selected next phase (load GREEN_TIME).
- Next-phase selection, evaluated in the final ALL_RED cycle:
  - If preempt is valid: choose preempt_phase.
  - Else: first phase with demand set, searching active_phase+1 upward with wrap from NUM_PHASES-1 to 0.
  - Else: active_phase+1 mod NUM_PHASES.
  - The active phase's own demand is considered last.
- Preempt:
  - Valid preempt targeting another phase while in GREEN: next cycle is YELLOW, count=YELLOW_TIME, regardless of remaining green.
  - Valid preempt targeting the active phase while in GREEN: count_down is frozen (no ticks, prescaler held).
  - In YELLOW and ALL_RED, preempt only affects selection.
  - If preempt drops before ALL_RED ends, normal selection applies.
- Safety invariants:
  - green|yellow is zero or one-hot.
  - Never green on two phases.
  - An ALL_RED of at least one cycle always separates two greens.

Decomposition:
- Package tpc_pkg:
  - state enum {ST_GREEN, ST_YELLOW, ST_ALL_RED}.
  - Default timing constants.
  - Function for lane-OR per phase.
- Sub-module tpc_rr_pick (combinational):
  - Inputs: request vector, start index.
  - Outputs: found flag, index.
  - Instantiated once for next-phase selection.

Test Plan:
- Reset, cars=0, defaults:
  - phase0 green with count 20, decrementing every 2 cycles.
  - YELLOW at cycle 40 with count 3; ALL_RED at cycle 43; phase1 green at cycle 44.
- Single-cycle pulse on phase2 lane 0 while phase0 green with count 18:
  - demand[2]=1; count now decrements every cycle.
  - After ALL_RED, phase2 green (phase1 skipped) and demand[2] cleared.
- preempt=1, preempt_phase=3 while phase0 green with count 15:
  - next cycle yellow[0] with count 3, then ALL_RED for 1 cycle, then green[3] with count 20.
  - count holds at 20 while preempt stays high; decrements resume after release.
- rst pulsed for one cycle during YELLOW of phase2:
  - next cycle green[0], count 20, demand=0, yellow=0.
- Phase3 green with no demand:
  - wrap to phase0.
- Phase2 active with demand[1] and demand[3] both set:
  - phase3 selected; demand[1] remains set and phase1 is served next.
